// File: rtl/spin_game_controller.sv
// Spin game sequencer: debounces the three board buttons and runs the
// select / spin / decelerate / settle play loop that feeds the renderer.

module spin_game_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    syncPipe;
  logic          level;
  logic [CW-1:0] stableCnt;

  // level flips only after DEBOUNCE_CYCLES synced samples that disagree with it
  always_ff @(posedge clk) begin
    if (rst) begin
      syncPipe  <= 2'b11;
      level     <= 1'b1;
      stableCnt <= '0;
      press     <= 1'b0;
    end else begin
      syncPipe <= {syncPipe[0], raw};
      press    <= 1'b0;
      if (syncPipe[1] == level) begin
        stableCnt <= '0;
      end else if (stableCnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stableCnt <= '0;
        level     <= syncPipe[1];
        press     <= ~syncPipe[1];
      end else begin
        stableCnt <= stableCnt + CW'(1);
      end
    end
  end
endmodule

module spin_game_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STEP_BASE       = 2_500_000,
  parameter int DECEL_STEPS     = 6,
  parameter int START_CREDITS   = 10,
  parameter int WIN_PAYOUT      = 5,
  parameter int CREDIT_W        = 8
) (
  input  logic                CLK100MHZ,
  input  logic                gameReset,
  input  logic                pbL,
  input  logic                pbR,
  input  logic                pbG,
  output logic [2:0]          selSlot,
  output logic [2:0]          wheelPos,
  output logic                spinning,
  output logic                resultValid,
  output logic                win,
  output logic [CREDIT_W-1:0] credits
);
  localparam int MAX_PERIOD = STEP_BASE << DECEL_STEPS;
  localparam int TW         = $clog2(MAX_PERIOD + 1);
  localparam int KW         = $clog2(DECEL_STEPS + 1);
  localparam int CW1        = CREDIT_W + 1;

  typedef enum logic [1:0] {IDLE, SPIN, DECEL, RESULT} state_t;

  state_t        state;
  logic [2:0]    rawBtn, pressBtn;
  logic          pressL, pressR, pressG;
  logic [TW-1:0] stepTimer, stepPeriod;
  logic          stepDue;
  logic [4:0]    fastLeft;
  logic [KW-1:0] decelK;
  logic [7:0]    lfsr;
  logic [2:0]    nextPos;
  logic [CW1-1:0] paidCredits;

  assign rawBtn = {pbG, pbR, pbL};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    spin_game_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (CLK100MHZ),
      .rst  (gameReset),
      .raw  (rawBtn[b]),
      .press(pressBtn[b])
    );
  end

  assign pressL = pressBtn[0];
  assign pressR = pressBtn[1];
  assign pressG = pressBtn[2];

  always_comb begin
    stepPeriod  = (state == DECEL) ? (TW'(STEP_BASE) << decelK) : TW'(STEP_BASE);
    stepDue     = (stepTimer == stepPeriod - TW'(1));
    nextPos     = wheelPos + 3'd1;
    paidCredits = {1'b0, credits} + CW1'(WIN_PAYOUT);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (gameReset) begin
      state       <= IDLE;
      selSlot     <= 3'd0;
      wheelPos    <= 3'd0;
      credits     <= CREDIT_W'(START_CREDITS);
      spinning    <= 1'b0;
      resultValid <= 1'b0;
      win         <= 1'b0;
      stepTimer   <= '0;
      fastLeft    <= 5'd0;
      decelK      <= '0;
      lfsr        <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        IDLE: begin
          // G wins over L/R even when it is refused for lack of credits
          if (pressG) begin
            if (credits != '0) begin
              state     <= SPIN;
              credits   <= credits - CREDIT_W'(1);
              fastLeft  <= {1'b1, lfsr[3:0]};
              stepTimer <= '0;
              spinning  <= 1'b1;
            end
          end else if (pressL && !pressR) begin
            selSlot <= selSlot - 3'd1;
          end else if (pressR && !pressL) begin
            selSlot <= selSlot + 3'd1;
          end
        end
        SPIN: begin
          if (stepDue) begin
            stepTimer <= '0;
            wheelPos  <= nextPos;
            fastLeft  <= fastLeft - 5'd1;
            if (fastLeft == 5'd1) begin
              state  <= DECEL;
              decelK <= KW'(1);
            end
          end else begin
            stepTimer <= stepTimer + TW'(1);
          end
        end
        DECEL: begin
          if (stepDue) begin
            stepTimer <= '0;
            wheelPos  <= nextPos;
            if (decelK == KW'(DECEL_STEPS)) begin
              state       <= RESULT;
              spinning    <= 1'b0;
              resultValid <= 1'b1;
              win         <= (nextPos == selSlot);
              if (nextPos == selSlot)
                credits <= paidCredits[CREDIT_W] ? '1 : paidCredits[CREDIT_W-1:0];
            end else begin
              decelK <= decelK + KW'(1);
            end
          end else begin
            stepTimer <= stepTimer + TW'(1);
          end
        end
        RESULT: begin
          if (pressG) begin
            state       <= IDLE;
            resultValid <= 1'b0;
            win         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spin_game_controller.sv
// Directed bench for spin_game_controller with a short debounce and step base.

module tb_spin_game_controller;
  logic       clk = 1'b0;
  logic       gameReset = 1'b1;
  logic       pbL = 1'b1, pbR = 1'b1, pbG = 1'b1;
  logic [2:0] selSlot, wheelPos;
  logic       spinning, resultValid, win;
  logic [7:0] credits;
  logic [7:0] mLfsr;
  int         nCmp = 0, nBad = 0;
  int         expCredits;

  always #5 clk = ~clk;

  spin_game_controller #(
    .DEBOUNCE_CYCLES(4), .STEP_BASE(2), .DECEL_STEPS(3),
    .START_CREDITS(10), .WIN_PAYOUT(5), .CREDIT_W(8)
  ) dut (
    .CLK100MHZ(clk), .gameReset(gameReset), .pbL(pbL), .pbR(pbR), .pbG(pbG),
    .selSlot(selSlot), .wheelPos(wheelPos), .spinning(spinning),
    .resultValid(resultValid), .win(win), .credits(credits)
  );

  function automatic logic [7:0] lfsrNext(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  // free-running reference LFSR, reset in lockstep with the design
  always @(posedge clk) mLfsr <= gameReset ? 8'h01 : lfsrNext(mLfsr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setBtn(input int which, input logic v);
    case (which)
      0: pbL = v;
      1: pbR = v;
      default: pbG = v;
    endcase
  endtask

  task automatic holdBtn(input int which, input int n);
    setBtn(which, 1'b0);
    repeat (n) @(negedge clk);
    setBtn(which, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  task automatic doReset();
    gameReset = 1'b1;
    @(negedge clk);
    gameReset = 1'b0;
    @(negedge clk);
    expCredits = 10;
  endtask

  // Picks a press cycle whose latched fastLeft yields the wanted outcome,
  // then follows the whole spin and settles back to IDLE.
  task automatic doSpin(input string tag, input bit wantWin);
    logic [7:0] adv;
    int fastExp, finalExp, cyc, last, steps, badFast, badDecel;
    logic [2:0] prevPos;
    bit found;
    found = 0;
    fastExp = 16;
    finalExp = 0;
    for (int t = 0; t < 300; t++) begin
      adv = mLfsr;
      repeat (6) adv = lfsrNext(adv);
      fastExp  = 16 + int'(adv[3:0]);
      finalExp = (int'(wheelPos) + fastExp + 3) % 8;
      if (((finalExp == int'(selSlot)) ? 1'b1 : 1'b0) == wantWin) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " press slot found"}, found, 1);
    pbG = 1'b0;
    cyc = 0;
    while (!spinning && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) pbG = 1'b1;
    end
    check({tag, " start latency"}, cyc, 7);
    check({tag, " credits at start"}, credits, expCredits - 1);
    expCredits--;
    last = cyc; steps = 0; badFast = 0; badDecel = 0; prevPos = wheelPos;
    while (!resultValid && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) pbG = 1'b1;
      if (wheelPos != prevPos) begin
        if (steps < fastExp) begin
          if (cyc - last != 2) badFast++;
        end else if (cyc - last != (4 << (steps - fastExp))) begin
          badDecel++;
        end
        steps++;
        last = cyc;
        prevPos = wheelPos;
      end
    end
    pbG = 1'b1;
    if (wantWin) expCredits = (expCredits + 5 > 255) ? 255 : expCredits + 5;
    check({tag, " resultValid"}, resultValid, 1);
    check({tag, " spinning off"}, spinning, 0);
    check({tag, " step count"}, steps, fastExp + 3);
    check({tag, " fast intervals"}, badFast, 0);
    check({tag, " decel intervals"}, badDecel, 0);
    check({tag, " final slot"}, wheelPos, finalExp);
    check({tag, " win"}, win, wantWin);
    check({tag, " credits settled"}, credits, expCredits);
    repeat (10) @(negedge clk);
    holdBtn(2, 10);
    check({tag, " back to idle"}, resultValid, 0);
    check({tag, " ack starts no spin"}, spinning, 0);
  endtask

  initial begin
    logic [7:0] adv;
    int fastExp;
    expCredits = 10;
    repeat (3) @(negedge clk);
    gameReset = 1'b0;
    @(negedge clk);
    check("reset credits", credits, 10);
    check("reset selSlot", selSlot, 0);
    check("reset wheelPos", wheelPos, 0);
    check("reset spinning", spinning, 0);
    check("reset resultValid", resultValid, 0);
    check("reset win", win, 0);

    holdBtn(0, 2);
    check("L glitch ignored", selSlot, 0);
    holdBtn(0, 10);
    check("L wraps 0->7", selSlot, 7);
    holdBtn(1, 10);
    check("R wraps 7->0", selSlot, 0);
    holdBtn(1, 10);
    check("R to 1", selSlot, 1);
    pbL = 1'b0; pbR = 1'b0;
    repeat (10) @(negedge clk);
    pbL = 1'b1; pbR = 1'b1;
    repeat (10) @(negedge clk);
    check("L+R together no change", selSlot, 1);

    doSpin("spin1", 1'b0);
    doSpin("winspin", 1'b1);

    doReset();
    for (int i = 0; i < 10; i++) doSpin("drain", 1'b0);
    check("drained credits", credits, 0);
    holdBtn(2, 10);
    check("G at zero credits stays idle", spinning, 0);
    check("G at zero credits keeps 0", credits, 0);

    doReset();
    doSpin("lose1", 1'b0);
    for (int i = 0; i < 61; i++) doSpin("climb", 1'b1);
    check("credits reach 253", credits, 253);
    doSpin("saturate", 1'b1);
    check("credits saturate 255", credits, 255);

    doReset();
    adv = mLfsr;
    repeat (6) adv = lfsrNext(adv);
    fastExp = 16 + int'(adv[3:0]);
    pbG = 1'b0;
    repeat (7) @(negedge clk);
    check("abort spin started", spinning, 1);
    repeat (3) @(negedge clk);
    pbG = 1'b1;
    repeat (2 * fastExp + 2) @(negedge clk);
    check("abort in decel spinning", spinning, 1);
    check("abort in decel no result", resultValid, 0);
    gameReset = 1'b1;
    @(negedge clk);
    gameReset = 1'b0;
    check("abort spinning cleared", spinning, 0);
    check("abort credits reloaded", credits, 10);
    check("abort wheelPos cleared", wheelPos, 0);
    check("abort selSlot cleared", selSlot, 0);
    check("abort resultValid", resultValid, 0);
    repeat (20) @(negedge clk);
    check("no stale pulse spinning", spinning, 0);
    check("no stale pulse credits", credits, 10);
    check("no stale pulse selSlot", selSlot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
